// File: rtl/divisor_pkg.sv
// Shared CPU definitions for the iterative divider.
// The control unit imports these to mirror the divide latency.
package divisor_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_ITER   = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_SIGN = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/divisor.sv
// Signed restoring divider with MIPS div semantics.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module divisor
    import divisor_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int ITER   = DIV_ITER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Div_control,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Div_Hi,
    output logic [DATA_W-1:0] Div_Lo,
    output logic              Div_done,
    output logic              Div_zero
);

    div_state_e state_q, state_d;

    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W:0]      rem_q, rem_d;
    logic [DATA_W-1:0]    quot_q, quot_d;
    logic [DATA_W-1:0]    bmag_q, bmag_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [DATA_W-1:0]    hi_q, hi_d;
    logic [DATA_W-1:0]    lo_q, lo_d;
    logic                 zero_q, zero_d;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    logic [DATA_W-1:0] rem_low;

    // 0x80000000 negates to itself, which is the right unsigned magnitude.
    assign a_mag = A[DATA_W-1] ? -A : A;
    assign b_mag = B[DATA_W-1] ? -B : B;

    // One restoring step: shift {rem,quot} left, trial-subtract |B|.
    assign shifted = {rem_q[DATA_W-1:0], quot_q[DATA_W-1]};
    assign diff    = {1'b0, shifted} - {2'b00, bmag_q};
    assign rem_low = rem_q[DATA_W-1:0];

    // Next-state and datapath update for the divide sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        bmag_d  = bmag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (Div_control) begin
                    if (B == '0) begin
                        zero_d  = 1'b1;
                        state_d = DIV_DONE;
                    end else begin
                        quot_d  = a_mag;
                        bmag_d  = b_mag;
                        sa_d    = A[DATA_W-1];
                        sb_d    = B[DATA_W-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        zero_d  = 1'b0;
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (!diff[DATA_W+1]) begin
                    rem_d  = diff[DATA_W:0];
                    quot_d = {quot_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d  = shifted;
                    quot_d = {quot_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == DIV_CNT_W'(ITER - 1)) begin
                    cnt_d   = '0;
                    state_d = DIV_SIGN;
                end else begin
                    cnt_d = cnt_q + DIV_CNT_W'(1);
                end
            end
            DIV_SIGN: begin
                lo_d    = (sa_q ^ sb_q) ? -quot_q : quot_q;
                hi_d    = sa_q ? -rem_low : rem_low;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and working registers; reset abandons any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            bmag_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            bmag_q  <= bmag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
        end
    end

    assign Div_Hi   = hi_q;
    assign Div_Lo   = lo_q;
    assign Div_zero = zero_q;
    assign Div_done = (state_q == DIV_DONE);

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 SHALL define parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL define parameter ITER, default 32: iterations, equal to DATA_W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Div_control  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port A  input  32  dividend (register A output), two's complement.
REQ-007 SHALL have port B  input  32  divisor (register B output), two's complement.
REQ-008 SHALL have port Div_Hi  output  32  remainder, driven to the HI-select mux.
REQ-009 SHALL have port Div_Lo  output  32  quotient, driven to the LO-select mux.
REQ-010 SHALL have port Div_done  output  1  one-cycle completion pulse to the control unit.
REQ-011 SHALL have port Div_zero  output  1  divide-by-zero flag for the exception path.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, SIGN, DONE.
REQ-013 IDLE, Div_control=1 at edge E0, B!=0: latch |A|, |B|, sign(A), sign(B); clear the partial remainder and counter; clear Div_zero; go to RUN.
REQ-014 IDLE, Div_control=1 at E0, B==0: go directly to DONE; set Div_zero=1; leave Div_Hi/Div_Lo unchanged.
REQ-015 RUN: perform one restoring step per edge: shift {rem,quot} left 1, trial-subtract |B|, keep the result if non-negative and set the quotient bit.
REQ-016 RUN SHALL last exactly ITER edges (E1..E32); the counter wraps to 0 on exit; the FSM then enters SIGN.
REQ-017 SIGN (edge E33): Div_Lo = quotient negated iff sign(A)!=sign(B); Div_Hi = remainder negated iff sign(A)=1; go to DONE.
REQ-018 Quotient SHALL truncate toward zero; the remainder SHALL carry the dividend's sign (MIPS div semantics).
REQ-019 0x80000000 / 0xFFFFFFFF SHALL produce Div_Lo=0x80000000 (wrap), Div_Hi=0, and no flag.
REQ-020 Magnitude of 0x80000000 SHALL be handled as unsigned 0x80000000 in a 33-bit working remainder.
REQ-021 DONE: Div_done=1 for exactly one cycle (decoded from state), then IDLE; normal latency is 33 edges from E0 to Div_done visible.
REQ-022 Div_control while not in IDLE SHALL be ignored; it shall not restart or corrupt an operation.
REQ-023 Div_Hi/Div_Lo SHALL hold the last result stable until the next SIGN; intermediate values shall never appear on them.
REQ-024 Div_zero SHALL hold until the next accepted start.
REQ-025 A and B SHALL be sampled only at E0; later changes shall not affect the result.

Reset
REQ-026 reset low SHALL immediately force IDLE and clear the counter, working registers, Div_Hi, Div_Lo, Div_done and Div_zero.
REQ-027 Reset mid-RUN or mid-SIGN SHALL abandon the operation; no partial result is visible afterwards.
REQ-028 After reset deasserts, the first edge with Div_control=1 SHALL start normally.

Structure
REQ-029 State encoding (2-bit) and ITER SHALL live in the shared CPU package used by the control unit, so the control unit can mirror the latency.
REQ-030 SHALL be a single module; no sub-module is required (negation/abs are inline).
REQ-031 SHALL contain a 6-bit counter, a 33-bit remainder register, a 32-bit quotient register, and sign bits.

Verification
REQ-032 A=100, B=7, start -> Div_done at 33 edges; Lo=14, Hi=2, Div_zero=0.
REQ-033 A=-100, B=7 -> Lo=0xFFFFFFF2 (-14), Hi=0xFFFFFFFE (-2); A=100, B=-7 -> Lo=-14, Hi=2.
REQ-034 Prior result Lo=14/Hi=2; A=5, B=0 -> Div_done next cycle, Div_zero=1, Lo=14, Hi=2 unchanged.
REQ-035 A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, no Div_zero.
REQ-036 Start 100/7, reset low at RUN iteration 10, release, start 9/3 -> all outputs 0 during reset; then Lo=3, Hi=0 at 33 edges.
REQ-037 Start 100/7, pulse Div_control with A=1, B=1 at iteration 5 -> ignored; result Lo=14, Hi=2 at the original time.
